// File: rtl/stream_throttle_pkg.sv
// Shared definitions for the randomised AXI-stream bench stages.
//   LFSR_POLY     - Galois feedback mask for the 16-bit throttle LFSR
//   DEFAULT_SEED  - LFSR start state when the instantiator gives none
//   THROTTLE_OFF  - stall weight that never stalls
//   THROTTLE_MAX  - stall weight that stalls 15 cycles out of 16
//   lfsr_step()   - one Galois step (shift right, fold in POLY on a 1 out)
//   safe_seed()   - maps the lock-up seed 0 to 1
package stream_throttle_pkg;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h0001;
  localparam logic [3:0]  THROTTLE_OFF = 4'd0;
  localparam logic [3:0]  THROTTLE_MAX = 4'd15;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  // An all-zero Galois LFSR never leaves zero.
  function automatic logic [15:0] safe_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/stream_throttle_if.sv
// AXI-stream style handshake bundle (valid/ready/data/last).
//   master modport: drives valid, data, last; receives ready
//   slave  modport: receives valid, data, last; drives ready
interface stream_throttle_if #(
  parameter int SW = 32
);
  logic          valid;
  logic          ready;
  logic [SW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/throttle_lfsr.sv
// Free-running 16-bit Galois LFSR used to pace randomised bench stages.
//   clk     - clock
//   rst_n   - synchronous active-low reset, loads SEED (0 becomes 1)
//   state_o - current LFSR state, advances every cycle out of reset
module throttle_lfsr
  import stream_throttle_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state_o
);

  localparam logic [15:0] SEED_EFF = safe_seed(SEED);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/stream_throttle.sv
// Bench-side AXI-stream stage: small FIFO with LFSR-driven input backpressure
// and output valid gaps, delivered beat/packet counters, and a sticky flag for
// upstream stability violations (valid dropped or payload changed while stalled).
//   S_ACLK, S_ARESETN - clock, synchronous active-low reset
//   i_throttle        - stall weight, 0 = never stall, 15 = stall 15/16
//   i_clear           - zeroes o_beats/o_packets and o_err
//   s_axis (slave)    - upstream stream (S_VALID/S_READY/S_DATA/S_LAST)
//   m_axis (master)   - downstream stream (M_VALID/M_READY/M_DATA/M_LAST)
//   o_beats           - M handshakes, wraps
//   o_packets         - M handshakes carrying LAST, wraps
//   o_err             - sticky upstream protocol-violation flag
module stream_throttle
  import stream_throttle_pkg::*;
#(
  parameter int          SW     = 32,
  parameter int          LGFIFO = 2,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic               S_ACLK,
  input  logic               S_ARESETN,
  input  logic [3:0]         i_throttle,
  input  logic               i_clear,
  stream_throttle_if.slave   s_axis,
  stream_throttle_if.master  m_axis,
  output logic [31:0]        o_beats,
  output logic [15:0]        o_packets,
  output logic               o_err
);

  localparam int              DEPTH   = 1 << LGFIFO;
  localparam logic [LGFIFO:0] PTR_ONE = {{LGFIFO{1'b0}}, 1'b1};

  logic [15:0] lfsr_state;
  logic        unused_lfsr_bits;

  throttle_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (S_ACLK),
    .rst_n   (S_ARESETN),
    .state_o (lfsr_state)
  );

  // Upper LFSR bits are not needed by this stage.
  assign unused_lfsr_bits = ^lfsr_state[15:8];

  logic in_gate;
  logic out_gate;
  assign in_gate  = (lfsr_state[3:0] >= i_throttle);
  assign out_gate = (lfsr_state[7:4] >= i_throttle);

  // FIFO entries hold {last, data}.
  logic [SW:0]     mem_q [DEPTH];
  logic [LGFIFO:0] wr_ptr_q, wr_ptr_d;
  logic [LGFIFO:0] rd_ptr_q, rd_ptr_d;
  logic            hold_q, hold_d;
  logic [31:0]     beats_q, beats_d;
  logic [15:0]     packets_q, packets_d;
  logic            err_q, err_d;
  logic            prev_stall_q, prev_stall_d;
  logic [SW-1:0]   prev_data_q, prev_data_d;
  logic            prev_last_q, prev_last_d;

  logic        full;
  logic        empty;
  logic        s_ready;
  logic        m_valid;
  logic        push;
  logic        pop;
  logic        violation;
  logic [SW:0] head;

  always_comb begin
    full  = (wr_ptr_q[LGFIFO] != rd_ptr_q[LGFIFO]) &&
            (wr_ptr_q[LGFIFO-1:0] == rd_ptr_q[LGFIFO-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    // Ready depends only on registered state, so a same-cycle pop never
    // opens a slot while full.
    s_ready = !full && in_gate;
    push    = s_axis.valid && s_ready;
    head    = mem_q[rd_ptr_q[LGFIFO-1:0]];
    // hold keeps a presented beat up until it is taken, regardless of out_gate.
    m_valid = !empty && (out_gate || hold_q);
    pop     = m_valid && m_axis.ready;
  end

  assign s_axis.ready = s_ready;
  assign m_axis.valid = m_valid;
  assign m_axis.data  = m_valid ? head[SW-1:0] : '0;
  assign m_axis.last  = m_valid && head[SW];

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    hold_d = hold_q;
    if (pop) begin
      hold_d = 1'b0;
    end else if (m_valid) begin
      hold_d = 1'b1;
    end

    beats_d   = beats_q;
    packets_d = packets_q;
    if (i_clear) begin
      beats_d   = '0;
      packets_d = '0;
    end else if (pop) begin
      beats_d = beats_q + 32'd1;
      if (head[SW]) begin
        packets_d = packets_q + 16'd1;
      end
    end

    // Snapshot the stalled offer; next cycle it must be repeated unchanged.
    prev_stall_d = s_axis.valid && !s_ready;
    prev_data_d  = s_axis.data;
    prev_last_d  = s_axis.last;
    violation    = prev_stall_q && (!s_axis.valid ||
                                    (s_axis.data != prev_data_q) ||
                                    (s_axis.last != prev_last_q));
    // A violation in the clearing cycle still gets recorded.
    if (violation) begin
      err_d = 1'b1;
    end else if (i_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge S_ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q[LGFIFO-1:0]] <= {s_axis.last, s_axis.data};
    end
  end

  always_ff @(posedge S_ACLK) begin
    if (!S_ARESETN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= 1'b0;
      beats_q      <= '0;
      packets_q    <= '0;
      err_q        <= 1'b0;
      prev_stall_q <= 1'b0;
      prev_data_q  <= '0;
      prev_last_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      beats_q      <= beats_d;
      packets_q    <= packets_d;
      err_q        <= err_d;
      prev_stall_q <= prev_stall_d;
      prev_data_q  <= prev_data_d;
      prev_last_q  <= prev_last_d;
    end
  end

  assign o_beats   = beats_q;
  assign o_packets = packets_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_stream_throttle.sv
// Randomised scoreboard bench for stream_throttle. The driver pushes each
// accepted beat into exp_q; the monitor pops on every M handshake. A reference
// model (occupancy count, pending-beat flag, counters, stall snapshot, LFSR
// sequence) predicts S_READY, M_VALID and the counters every cycle.
module tb_stream_throttle;
  import stream_throttle_pkg::*;

  localparam int SW    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic [3:0]  thr;
  logic [31:0] o_beats;
  logic [15:0] o_packets;
  logic        o_err;

  stream_throttle_if #(.SW(SW)) s_if ();
  stream_throttle_if #(.SW(SW)) m_if ();

  stream_throttle #(.SW(SW), .LGFIFO(2), .SEED(DEFAULT_SEED)) dut (
    .S_ACLK     (clk),
    .S_ARESETN  (rstn),
    .i_throttle (thr),
    .i_clear    (clr),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .o_beats    (o_beats),
    .o_packets  (o_packets),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          t1_waits = 0;
  bit          rand_ready = 1'b0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Spec LFSR: 16-bit Galois, right shift, XOR B400 when a 1 falls out.
  function automatic logic [15:0] model_lfsr(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // ---------------- reference model + monitor ----------------
  logic [15:0] lfsr_m;
  int          occ_m;
  bit          hold_m, live_m, pstall_m, plast_m, err_m;
  logic [31:0] pdata_m, beats_m;
  logic [15:0] pkts_m;

  always @(negedge clk) begin
    bit          exp_sr, exp_mv, push_m, pop_m, pop_last, viol;
    logic [32:0] item;
    pop_last = 1'b0;
    exp_sr   = 1'b0;
    exp_mv   = 1'b0;
    if (live_m) begin
      exp_sr = (occ_m < DEPTH) && (lfsr_m[3:0] >= thr);
      exp_mv = (occ_m > 0) && ((lfsr_m[7:4] >= thr) || hold_m);
      chk("s_ready", s_if.ready, exp_sr);
      chk("m_valid", m_if.valid, exp_mv);
      chk("o_beats", o_beats, beats_m);
      chk("o_packets", o_packets, pkts_m);
      chk("o_err", o_err, err_m);
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          fail_now("m_unexpected_beat");
        end else begin
          item = exp_q.pop_front();
          chk("m_data", m_if.data, item[31:0]);
          chk("m_last", m_if.last, item[32]);
          pop_last = item[32];
        end
      end
      if (!m_if.valid) chk("m_idle_zero", {m_if.last, m_if.data}, 33'h0);
    end
    if (!rstn) begin
      lfsr_m = DEFAULT_SEED; occ_m = 0; hold_m = 0; pstall_m = 0;
      plast_m = 0; pdata_m = 0; err_m = 0; beats_m = 0; pkts_m = 0;
      exp_q.delete();
      live_m = 1'b1;
    end else if (live_m) begin
      push_m = s_if.valid && exp_sr;
      pop_m  = exp_mv && m_if.ready;
      viol   = pstall_m && (!s_if.valid || (s_if.data !== pdata_m) || (s_if.last !== plast_m));
      occ_m  = occ_m + int'(push_m) - int'(pop_m);
      hold_m = pop_m ? 1'b0 : (exp_mv ? 1'b1 : hold_m);
      if (clr) begin
        beats_m = 0; pkts_m = 0;
      end else if (pop_m) begin
        beats_m = beats_m + 1;
        if (pop_last) pkts_m = pkts_m + 1;
      end
      err_m    = viol ? 1'b1 : (clr ? 1'b0 : err_m);
      pstall_m = s_if.valid && !exp_sr;
      pdata_m  = s_if.data;
      plast_m  = s_if.last;
      lfsr_m   = model_lfsr(lfsr_m);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_if.ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    forever begin
      @(negedge clk);
      if (s_if.ready) begin
        exp_q.push_back({l, d});
        n_acc++;
        break;
      end
      t1_waits++;
      n++;
      if (n > 2000) begin
        fail_now("send_timeout");
        break;
      end
      tick();
    end
    tick();
    s_if.valid = 1'b0;
    s_if.data  = $urandom;
    s_if.last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          n;
    logic [31:0] held;
    rstn = 1'b0; clr = 1'b0; thr = THROTTLE_OFF;
    s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_m_valid", m_if.valid, 1'b0);
    chk("reset_beats", o_beats, 32'd0);
    tick();

    // 1: pass-through
    t1_waits = 0;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    drain();
    chk("t1_sready_waits", t1_waits, 0);
    chk("t1_beats", o_beats, 32'd8);
    chk("t1_packets", o_packets, 16'd1);

    // 2: full FIFO, no pass-through when full
    m_if.ready = 1'b0;
    base = n_acc;
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    s_if.valid = 1'b1; s_if.data = 32'd5; s_if.last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_full_sready", s_if.ready, 1'b0);
      tick();
    end
    chk("t2_accepted", n_acc - base, 4);
    m_if.ready = 1'b1;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    drain();

    // 3: heavy throttle, one 512-beat packet with random gaps and ready
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clear_beats", o_beats, 32'd0);
    thr = THROTTLE_MAX;
    rand_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send($urandom, i == 511);
    end
    drain();
    chk("t3_beats", o_beats, 32'd512);
    chk("t3_packets", o_packets, 16'd1);
    chk("t3_err", o_err, 1'b0);

    // random phase: varying throttle, random LAST positions
    for (int i = 0; i < 160; i++) begin
      if (i % 32 == 0) thr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) tick();
      send($urandom, $urandom_range(0, 7) == 0);
    end
    drain();

    // 4: valid hold
    rand_ready = 1'b0;
    m_if.ready = 1'b0;
    thr = 4'd8;
    send(32'hCAFE0004, 1'b1);
    n = 0;
    @(negedge clk);
    while (!m_if.valid && n < 500) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!m_if.valid) fail_now("t4_valid_timeout");
    held = m_if.data;
    chk("t4_data", held, 32'hCAFE0004);
    repeat (10) begin
      tick();
      @(negedge clk);
      chk("t4_hold_valid", m_if.valid, 1'b1);
      chk("t4_hold_data", m_if.data, held);
    end
    tick();
    m_if.ready = 1'b1;
    drain();

    // 5: upstream violation
    thr = THROTTLE_OFF;
    m_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(100 + i), 1'b0);
    s_if.valid = 1'b1; s_if.data = 32'd5; s_if.last = 1'b0;
    @(negedge clk);
    chk("t5_stall", s_if.ready, 1'b0);
    tick();
    s_if.data = 32'd6;
    @(negedge clk);
    chk("t5_err_before", o_err, 1'b0);
    tick();
    @(negedge clk);
    chk("t5_err_set", o_err, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_sticky", o_err, 1'b1);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", o_err, 1'b0);
    chk("t5_beats_cleared", o_beats, 32'd0);
    tick();
    m_if.ready = 1'b1;
    send(32'd6, 1'b0);
    send(32'd7, 1'b1);
    drain();

    // 6: mid-packet reset
    m_if.ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(32'(200 + i), 1'b0);
    tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    @(negedge clk);
    chk("t6_m_valid", m_if.valid, 1'b0);
    chk("t6_beats", o_beats, 32'd0);
    chk("t6_err", o_err, 1'b0);
    tick();
    m_if.ready = 1'b1;
    send(32'h11, 1'b0);
    send(32'h22, 1'b1);
    drain();
    chk("t6_new_beats", o_beats, 32'd2);
    chk("t6_new_packets", o_packets, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
